// File: rtl/nvram_upload_server.sv
// Serves hps_io upload requests from the battery-backed CMOS RAM.
// While an upload session is open it holds the CPU off that RAM with pause_cpu.
//
// state | meaning
// IDLE  | no session; CPU runs freely
// PAUSE | session open; waiting for the CPU's in-flight CMOS access to finish
// ARMED | CPU held off; waiting for a byte request
// READ  | RAM latency down-count; the byte is returned when the count expires
module nvram_upload_server #(
    parameter logic [7:0] INDEX   = 8'd4,
    parameter int         AW      = 10,
    parameter int         RAM_LAT = 1
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [7:0]    ram_q,
    output logic          pause_cpu,
    input  logic          cpu_ram_busy,
    input  logic          cpu_ram_wr,
    output logic          nv_dirty
);

    typedef enum logic [1:0] {S_IDLE, S_PAUSE, S_ARMED, S_READ} state_t;

    localparam logic [1:0] LAT_CNT = 2'(RAM_LAT);

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic          pending_q, pending_d;
    logic [24:0]   req_addr_q, req_addr_d;
    logic          oor_q, oor_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          full_seen_q, full_seen_d;
    logic [7:0]    din_q, din_d;
    logic          wait_q, wait_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_rd_q, ram_rd_d;
    logic          pause_q, pause_d;
    logic          dirty_q, dirty_d;

    logic [24:0]   cur_addr;
    logic          cur_oor;
    logic          dirty_clr;

    always_comb begin
        state_d     = state_q;
        sel_d       = ioctl_upload && (ioctl_index == INDEX);
        pending_d   = pending_q;
        req_addr_d  = req_addr_q;
        oor_d       = oor_q;
        cnt_d       = cnt_q;
        full_seen_d = full_seen_q;
        din_d       = din_q;
        wait_d      = wait_q;
        ram_addr_d  = ram_addr_q;
        ram_rd_d    = 1'b0;
        pause_d     = pause_q;
        dirty_clr   = 1'b0;
        // A request latched during PAUSE is served with the address it carried.
        cur_addr    = pending_q ? req_addr_q : ioctl_addr;
        cur_oor     = (cur_addr[24:AW] != '0);

        // Session end (or index change) takes priority over any read in flight.
        if (state_q != S_IDLE && !sel_q) begin
            state_d   = S_IDLE;
            pause_d   = 1'b0;
            wait_d    = 1'b0;
            pending_d = 1'b0;
            dirty_clr = full_seen_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sel_q) begin
                        state_d     = S_PAUSE;
                        pause_d     = 1'b1;
                        full_seen_d = 1'b0;
                        pending_d   = 1'b0;
                    end
                end
                S_PAUSE: begin
                    pause_d = 1'b1;
                    if (ioctl_rd) begin
                        pending_d  = 1'b1;
                        req_addr_d = ioctl_addr;
                        wait_d     = 1'b1;
                    end
                    if (!cpu_ram_busy) begin
                        state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (ioctl_rd || pending_q) begin
                        pending_d = 1'b0;
                        wait_d    = 1'b1;
                        cnt_d     = LAT_CNT;
                        oor_d     = cur_oor;
                        if (!cur_oor) begin
                            ram_addr_d = cur_addr[AW-1:0];
                            ram_rd_d   = 1'b1;
                            if (cur_addr[AW-1:0] == '1) begin
                                full_seen_d = 1'b1;
                            end
                        end
                        state_d = S_READ;
                    end
                end
                S_READ: begin
                    if (cnt_q == 2'd0) begin
                        din_d   = oor_q ? 8'hFF : ram_q;
                        wait_d  = 1'b0;
                        state_d = S_ARMED;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A CPU write in the clearing cycle still leaves the image dirty.
        dirty_d = (dirty_q && !dirty_clr) || cpu_ram_wr;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sel_q       <= 1'b0;
            pending_q   <= 1'b0;
            req_addr_q  <= '0;
            oor_q       <= 1'b0;
            cnt_q       <= 2'd0;
            full_seen_q <= 1'b0;
            din_q       <= 8'h00;
            wait_q      <= 1'b0;
            ram_addr_q  <= '0;
            ram_rd_q    <= 1'b0;
            pause_q     <= 1'b0;
            dirty_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            pending_q   <= pending_d;
            req_addr_q  <= req_addr_d;
            oor_q       <= oor_d;
            cnt_q       <= cnt_d;
            full_seen_q <= full_seen_d;
            din_q       <= din_d;
            wait_q      <= wait_d;
            ram_addr_q  <= ram_addr_d;
            ram_rd_q    <= ram_rd_d;
            pause_q     <= pause_d;
            dirty_q     <= dirty_d;
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign ram_addr   = ram_addr_q;
    assign ram_rd     = ram_rd_q;
    assign pause_cpu  = pause_q;
    assign nv_dirty   = dirty_q;

endmodule

// File: tb/tb_nvram_upload_server.sv
// Bench for nvram_upload_server: two instances (RAM_LAT 1 and 2) share stimulus;
// a scoreboard queue per instance is drained by a monitor on falling ioctl_wait.
module tb_nvram_upload_server;

    localparam int AW = 10;

    typedef struct {
        logic [7:0] data;
        int         issue;
    } exp_t;

    logic          clk_sys;
    logic          reset;
    logic          ioctl_upload;
    logic [7:0]    ioctl_index;
    logic          ioctl_rd;
    logic [24:0]   ioctl_addr;
    logic          cpu_ram_busy;
    logic          cpu_ram_wr;

    logic [7:0]    din_w      [2];
    logic          wait_w     [2];
    logic [AW-1:0] ram_addr_w [2];
    logic          ram_rd_w   [2];
    logic [7:0]    ram_q_w    [2];
    logic          pause_w    [2];
    logic          dirty_w    [2];

    logic [7:0]    mem [1024];
    exp_t          q0[$];
    exp_t          q1[$];
    int            rd_cnt [2];
    int            cyc;
    int            n_cmp;
    int            n_bad;

    function automatic logic [7:0] img(input int a);
        logic [9:0] v;
        v = 10'(a);
        return v[7:0] ^ {v[9:8], 6'b0};
    endfunction

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            logic [7:0] pipe [3];
            nvram_upload_server #(.INDEX(8'd4), .AW(AW), .RAM_LAT(g + 1)) u_dut (
                .clk_sys      (clk_sys),
                .reset        (reset),
                .ioctl_upload (ioctl_upload),
                .ioctl_index  (ioctl_index),
                .ioctl_rd     (ioctl_rd),
                .ioctl_addr   (ioctl_addr),
                .ioctl_din    (din_w[g]),
                .ioctl_wait   (wait_w[g]),
                .ram_addr     (ram_addr_w[g]),
                .ram_rd       (ram_rd_w[g]),
                .ram_q        (ram_q_w[g]),
                .pause_cpu    (pause_w[g]),
                .cpu_ram_busy (cpu_ram_busy),
                .cpu_ram_wr   (cpu_ram_wr),
                .nv_dirty     (dirty_w[g])
            );
            // RAM model: data appears g+1 cycles after the ram_rd strobe is sampled
            always_ff @(posedge clk_sys) begin
                if (ram_rd_w[g]) pipe[0] <= mem[ram_addr_w[g]];
                pipe[1] <= pipe[0];
                pipe[2] <= pipe[1];
            end
            assign ram_q_w[g] = pipe[g];
        end
    endgenerate

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk_sys);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        logic prev [2];
        int   rise [2];
        exp_t e;
        prev = '{1'b0, 1'b0};
        rise = '{0, 0};
        forever begin
            @(negedge clk_sys);
            for (int g = 0; g < 2; g++) begin
                if (ram_rd_w[g]) rd_cnt[g]++;
                if (!prev[g] && wait_w[g]) rise[g] = cyc;
                if (prev[g] && !wait_w[g]) begin
                    if ((g == 0 && q0.size() > 0) || (g == 1 && q1.size() > 0)) begin
                        if (g == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        check($sformatf("din_lat%0d", g + 1), din_w[g], e.data);
                        check($sformatf("wait_rise_lat%0d", g + 1), rise[g] - e.issue, 0);
                        check($sformatf("wait_fall_lat%0d", g + 1), cyc - e.issue, g + 2);
                    end
                end
                prev[g] = wait_w[g];
            end
        end
    end

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("%s_din%0d", tag, g), din_w[g], 0);
            check($sformatf("%s_wait%0d", tag, g), wait_w[g], 0);
            check($sformatf("%s_ram_addr%0d", tag, g), ram_addr_w[g], 0);
            check($sformatf("%s_ram_rd%0d", tag, g), ram_rd_w[g], 0);
            check($sformatf("%s_pause%0d", tag, g), pause_w[g], 0);
            check($sformatf("%s_dirty%0d", tag, g), dirty_w[g], 0);
        end
    endtask

    task automatic check_dirty(input string tag, input logic exp);
        for (int g = 0; g < 2; g++) check($sformatf("%s_dirty%0d", tag, g), dirty_w[g], exp);
    endtask

    task automatic pulse_wr;
        cpu_ram_wr = 1'b1;
        tick;
        cpu_ram_wr = 1'b0;
    endtask

    task automatic start_session(input logic [7:0] idx);
        ioctl_upload = 1'b1;
        ioctl_index  = idx;
        tick;
        tick;
        tick;
    endtask

    task automatic end_session(input logic wr_on_clear);
        ioctl_upload = 1'b0;
        tick;
        for (int g = 0; g < 2; g++) check($sformatf("pause_hold%0d", g), pause_w[g], 1);
        cpu_ram_wr = wr_on_clear;
        tick;
        cpu_ram_wr = 1'b0;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("pause_rel%0d", g), pause_w[g], 0);
            check($sformatf("wait_rel%0d", g), wait_w[g], 0);
        end
    endtask

    task automatic do_read(input logic [24:0] a);
        exp_t e;
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        e.data  = (a < 25'd1024) ? img(int'(a)) : 8'hFF;
        e.issue = cyc + 1;
        q0.push_back(e);
        q1.push_back(e);
        tick;
        ioctl_rd = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (!wait_w[0] && !wait_w[1]) break;
            tick;
        end
        check("read_done", {wait_w[0], wait_w[1]}, 0);
    endtask

    task automatic dump(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) do_read(25'(a));
    endtask

    initial begin
        int         base [2];
        logic [7:0] saved [2];
        n_cmp = 0;
        n_bad = 0;
        rd_cnt = '{0, 0};
        for (int i = 0; i < 1024; i++) mem[i] = img(i);
        reset        = 1'b1;
        ioctl_upload = 1'b0;
        ioctl_index  = 8'd0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        cpu_ram_busy = 1'b0;
        cpu_ram_wr   = 1'b0;

        // T1 reset
        tick;
        tick;
        check_reset_vals("reset");
        reset = 1'b0;
        tick;
        tick;
        for (int g = 0; g < 2; g++) check($sformatf("idle_pause%0d", g), pause_w[g], 0);

        // T2 session start with CPU busy, then one in-range read
        ioctl_upload = 1'b1;
        ioctl_index  = 8'd4;
        cpu_ram_busy = 1'b1;
        base = rd_cnt;
        for (int k = 0; k < 5; k++) tick;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("pause_busy%0d", g), pause_w[g], 1);
            check($sformatf("no_rd_busy%0d", g), rd_cnt[g], base[g]);
        end
        cpu_ram_busy = 1'b0;
        tick;
        do_read(25'h005);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("one_rd%0d", g), rd_cnt[g], base[g] + 1);
            check($sformatf("ram_addr%0d", g), ram_addr_w[g], 10'h005);
        end

        // T3 out-of-range addresses return FF without touching the RAM
        base = rd_cnt;
        do_read(25'h400);
        do_read(25'h1405);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("oor_no_rd%0d", g), rd_cnt[g], base[g]);
            check($sformatf("oor_ram_addr%0d", g), ram_addr_w[g], 10'h005);
        end
        end_session(1'b0);
        check_dirty("clean_start", 1'b0);

        // T4 full dump clears dirty
        pulse_wr;
        check_dirty("wr_set", 1'b1);
        start_session(8'd4);
        dump(0, 1023);
        end_session(1'b0);
        check_dirty("full_clear", 1'b0);

        // T5 partial dump keeps dirty; write racing the clear wins
        pulse_wr;
        start_session(8'd4);
        dump(0, 511);
        end_session(1'b0);
        check_dirty("partial_keep", 1'b1);
        start_session(8'd4);
        dump(0, 1023);
        end_session(1'b1);
        check_dirty("race_keep", 1'b1);
        start_session(8'd4);
        dump(0, 1023);
        end_session(1'b0);
        check_dirty("full_clear2", 1'b0);

        // T6 wrong index never pauses
        ioctl_upload = 1'b1;
        ioctl_index  = 8'd3;
        for (int k = 0; k < 4; k++) tick;
        for (int g = 0; g < 2; g++) check($sformatf("wrong_idx_pause%0d", g), pause_w[g], 0);
        ioctl_upload = 1'b0;
        tick;

        // T6 abort during READ abandons the read
        start_session(8'd4);
        saved = din_w;
        ioctl_addr   = 25'h007;
        ioctl_rd     = 1'b1;
        tick;
        ioctl_rd     = 1'b0;
        ioctl_upload = 1'b0;
        tick;
        for (int g = 0; g < 2; g++) check($sformatf("abort_inflight%0d", g), wait_w[g], 1);
        tick;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("abort_wait%0d", g), wait_w[g], 0);
            check($sformatf("abort_pause%0d", g), pause_w[g], 0);
            check($sformatf("abort_din%0d", g), din_w[g], saved[g]);
        end

        // T6 reset during READ
        pulse_wr;
        start_session(8'd4);
        ioctl_addr = 25'h009;
        ioctl_rd   = 1'b1;
        tick;
        ioctl_rd     = 1'b0;
        reset        = 1'b1;
        ioctl_upload = 1'b0;
        tick;
        check_reset_vals("mid_reset");
        reset = 1'b0;
        tick;
        tick;

        check("sb_empty_lat1", q0.size(), 0);
        check("sb_empty_lat2", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
